// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Shared helpers for the pipelined adder tree: tree depth and
//   per-level element counts, used by the top level to size the
//   generate loop and the per-level arrays.
package adder_tree_pkg;

  // Number of register levels needed to reduce n operands to one.
  function automatic int tree_level_count(int n);
    return $clog2(n);
  endfunction

  // Element count of level k; level 0 is the raw operand vector.
  // Each level halves the count, rounding up for the odd pass-through.
  function automatic int level_size(int n, int k);
    int m;
    m = n;
    for (int unsigned i = 0; i < unsigned'(k); i++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// adder_tree_stage
//   One registered level of the reduction tree. Adds adjacent input
//   pairs (2i, 2i+1); with an odd input count the last input is passed
//   through unchanged so the data alignment between levels is preserved.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high clear of every output register
//   in_advance stage load enable; 0 holds every register
//   in_data    N_IN signed operands of WIDTH bits
//   out_data   ceil(N_IN/2) registered results of WIDTH bits
module adder_tree_stage #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_advance,
  input  logic signed [WIDTH-1:0] in_data  [N_IN],
  output logic signed [WIDTH-1:0] out_data [N_OUT]
);

  localparam int N_PAIRS = N_IN / 2;

  for (genvar i = 0; i < N_PAIRS; i++) begin : g_pair
    always_ff @(posedge clk) begin
      if (reset) begin
        out_data[i] <= '0;
      end else if (in_advance) begin
        out_data[i] <= in_data[2*i] + in_data[2*i+1];
      end
    end
  end

  // Pass-through register for the unpaired last element; it must obey the
  // same reset/advance as the adders or its operand would drift a cycle.
  if ((N_IN % 2) != 0) begin : g_odd
    always_ff @(posedge clk) begin
      if (reset) begin
        out_data[N_OUT-1] <= '0;
      end else if (in_advance) begin
        out_data[N_OUT-1] <= in_data[N_IN-1];
      end
    end
  end

endmodule

// File: rtl/adder_tree_pipelined.sv
// adder_tree_pipelined
//   Pipelined signed reduction tree: sums LENGTH signed DATA_WIDTH operands
//   into one full-precision OUT_WIDTH result, one register stage per tree
//   level, latency $clog2(LENGTH) advancing edges, one result per cycle.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high clear of all stage registers
//   in_advance global pipeline enable; 0 freezes every stage
//   in_addends LENGTH signed operands sampled on an advancing edge
//   out_sum    registered sum (combinational sign extension when LENGTH=1)
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 8,
  localparam int OUT_WIDTH = DATA_WIDTH + $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_advance,
  input  logic signed [DATA_WIDTH-1:0] in_addends [LENGTH],
  output logic signed [OUT_WIDTH-1:0]  out_sum
);

  localparam int NLEVELS = tree_level_count(LENGTH);

  // Level k occupies lvl[k][0 .. level_size(LENGTH,k)-1]; the remaining
  // slots of each row are tied to zero so the array is fully driven.
  logic signed [OUT_WIDTH-1:0] lvl [NLEVELS+1][LENGTH];

  for (genvar j = 0; j < LENGTH; j++) begin : g_ext
    assign lvl[0][j] = OUT_WIDTH'(in_addends[j]);
  end

  for (genvar k = 1; k <= NLEVELS; k++) begin : g_level
    localparam int N_IN  = level_size(LENGTH, k - 1);
    localparam int N_OUT = level_size(LENGTH, k);

    logic signed [OUT_WIDTH-1:0] stage_in  [N_IN];
    logic signed [OUT_WIDTH-1:0] stage_out [N_OUT];

    for (genvar j = 0; j < N_IN; j++) begin : g_in
      assign stage_in[j] = lvl[k-1][j];
    end

    adder_tree_stage #(
      .WIDTH (OUT_WIDTH),
      .N_IN  (N_IN)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .in_advance (in_advance),
      .in_data    (stage_in),
      .out_data   (stage_out)
    );

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign lvl[k][j] = stage_out[j];
    end

    for (genvar j = N_OUT; j < LENGTH; j++) begin : g_fill
      assign lvl[k][j] = '0;
    end
  end

  // With LENGTH == 1 there are no levels: this is the combinational bypass.
  assign out_sum = lvl[NLEVELS][0];

endmodule

// File: tb/tb_adder_tree_pipelined.sv
module tb_adder_tree_pipelined;

  logic clk = 1'b0;
  logic reset;
  logic in_advance;

  logic signed [4:0] a9 [9];
  logic signed [4:0] a1 [1];
  logic signed [4:0] a2 [2];
  logic signed [4:0] a8 [8];
  logic signed [8:0] s9;
  logic signed [4:0] s1;
  logic signed [5:0] s2;
  logic signed [7:0] s8;

  int total = 0;
  int bad   = 0;

  int exp1 [40];
  int exp2 [40];
  int exp8 [40];

  always #5 clk = ~clk;

  adder_tree_pipelined #(.DATA_WIDTH(5), .LENGTH(9)) dut9 (
    .clk(clk), .reset(reset), .in_advance(in_advance), .in_addends(a9), .out_sum(s9));
  adder_tree_pipelined #(.DATA_WIDTH(5), .LENGTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_advance(in_advance), .in_addends(a1), .out_sum(s1));
  adder_tree_pipelined #(.DATA_WIDTH(5), .LENGTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_advance(in_advance), .in_addends(a2), .out_sum(s2));
  adder_tree_pipelined #(.DATA_WIDTH(5), .LENGTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_advance(in_advance), .in_addends(a8), .out_sum(s8));

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Advance to #1 after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 9; i++) a9[i] = 5'(v);
  endtask

  task automatic set_basic();
    int v [9] = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    for (int i = 0; i < 9; i++) a9[i] = 5'(v[i]);
  endtask

  initial begin
    reset      = 1'b1;
    in_advance = 1'b1;
    set_all(0);
    a1[0] = '0;
    for (int i = 0; i < 2; i++) a2[i] = '0;
    for (int i = 0; i < 8; i++) a8[i] = '0;

    // Reset state
    tick();
    tick();
    check("reset_s9", s9, 0);
    check("reset_s8", s8, 0);
    check("reset_s2", s2, 0);

    // Basic sum, followed by garbage
    reset = 1'b0;
    set_basic();
    tick();
    for (int i = 0; i < 9; i++) a9[i] = 'x;
    check("basic_e1", s9, 0);
    tick();
    set_all(0);
    check("basic_e2", s9, 0);
    tick();
    check("basic_e3", s9, 0);
    tick();
    check("basic_e4", s9, 5);
    for (int i = 0; i < 4; i++) tick();

    // Extremes back to back
    set_all(-16);
    tick();
    set_all(15);
    tick();
    set_all(0);
    tick();
    tick();
    check("min_sum", s9, -144);
    tick();
    check("max_sum", s9, 135);
    for (int i = 0; i < 4; i++) tick();

    // Streaming: 1s, 2s, basic
    set_all(1);
    tick();
    set_all(2);
    tick();
    set_basic();
    tick();
    set_all(0);
    tick();
    check("stream_0", s9, 9);
    tick();
    check("stream_1", s9, 18);
    tick();
    check("stream_2", s9, 5);
    for (int i = 0; i < 4; i++) tick();

    // Stall: 1s, 3s, then three held cycles with junk on the inputs
    set_all(1);
    tick();
    set_all(3);
    tick();
    set_all(0);
    tick();
    tick();
    check("stall_pre", s9, 9);
    in_advance = 1'b0;
    set_all(7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), s9, 9);
    end
    in_advance = 1'b1;
    set_all(0);
    tick();
    check("stall_post", s9, 27);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_nojunk%0d", i), s9, 0);
    end
    tick();

    // Reset while sums are in flight
    set_all(1);
    tick();
    set_all(2);
    tick();
    set_all(3);
    tick();
    set_all(5);
    reset = 1'b1;
    tick();
    check("rst_e0", s9, 0);
    reset = 1'b0;
    set_all(-1);
    tick();
    set_all(0);
    check("rst_e1", s9, 0);
    tick();
    check("rst_e2", s9, 0);
    tick();
    check("rst_e3", s9, 0);
    tick();
    check("rst_new", s9, -9);
    tick();
    check("rst_after", s9, 0);

    // Parameter sweep: LENGTH 1, 2, 8 with random vectors
    for (int c = 0; c < 40; c++) begin
      int sum;
      if (c >= 1) check($sformatf("l2_c%0d", c), s2, exp2[c-1]);
      if (c >= 3) check($sformatf("l8_c%0d", c), s8, exp8[c-3]);
      a1[0] = 5'(int'($urandom_range(0, 31)) - 16);
      exp1[c] = int'(a1[0]);
      sum = 0;
      for (int i = 0; i < 2; i++) begin
        a2[i] = 5'(int'($urandom_range(0, 31)) - 16);
        sum += int'(a2[i]);
      end
      exp2[c] = sum;
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        a8[i] = 5'(int'($urandom_range(0, 31)) - 16);
        sum += int'(a8[i]);
      end
      exp8[c] = sum;
      #1;
      check($sformatf("l1_c%0d", c), s1, exp1[c]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
